// File: rtl/counter_sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_sweep_pkg
//  Description : Shared types and constants for the counter sweep controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_sweep_pkg;

    // Controller states. Width is fixed at 3 bits so the encoding is stable.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_UP_STEP = 3'd3,
        ST_DN_STEP = 3'd4,
        ST_FIN     = 3'd5
    } sweep_state_t;

    // Direction of the sweep currently in progress.
    typedef enum logic {
        PH_UP = 1'b0,
        PH_DN = 1'b1
    } sweep_phase_t;

    // The Counter's flags lag a pulse by two cycles, so fewer settle cycles
    // would sample stale flags.
    localparam int MIN_SETTLE = 2;

endpackage : counter_sweep_pkg
`default_nettype wire

// File: rtl/counter_sweep_if.sv
`default_nettype none
// ============================================================================
//  Module      : counter_sweep_if
//  Description : System command/status and Counter control/flag signals of
//                the sweep controller, bundled with direction modports.
//  Revision    : 1.0 - initial release
// ============================================================================
interface counter_sweep_if #(
    parameter int WIDTH = 4,
    parameter int NSW_W = 8
);
    // System side
    logic             start;
    logic [WIDTH-1:0] sweep_to;
    logic [NSW_W-1:0] n_sweeps;
    logic             abort;
    logic             busy;
    logic             done;
    logic             error;
    logic [NSW_W-1:0] sweeps_done;

    // Counter side
    logic [WIDTH-1:0] count_to;
    logic             load_en;
    logic             count_inc;
    logic             count_dec;
    logic             flag_count_max;
    logic             flag_count_min;

    // Controller view
    modport master (
        input  start, sweep_to, n_sweeps, abort, flag_count_max, flag_count_min,
        output count_to, load_en, count_inc, count_dec, busy, done, error, sweeps_done
    );

    // Environment view (system plus Counter)
    modport slave (
        output start, sweep_to, n_sweeps, abort, flag_count_max, flag_count_min,
        input  count_to, load_en, count_inc, count_dec, busy, done, error, sweeps_done
    );

endinterface : counter_sweep_if
`default_nettype wire

// File: rtl/counter_settle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : counter_settle_timer
//  Description : Loadable down-counter that stops at zero; zero_o marks the
//                last cycle of a settle window.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_settle_timer #(
    parameter int TW = 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          load_i,
    input  wire logic [TW-1:0] load_val_i,
    output logic               zero_o
);

    logic [TW-1:0] cnt_q;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - TW'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule : counter_settle_timer
`default_nettype wire

// File: rtl/counter_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : counter_sweep_ctrl
//  Description : Drives an up/down Counter through n up-then-down sweeps to a
//                loaded target, with abort, progress count and a stuck-flag
//                (step overrun) error.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_sweep_ctrl
    import counter_sweep_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int SETTLE_CYC = 2,
    parameter int NSW_W      = 8
) (
    input  wire logic       clk,
    input  wire logic       reset,
    counter_sweep_if.master bus
);

    // Too short a settle window is raised to the Counter's flag latency.
    localparam int SETTLE_EFF = (SETTLE_CYC < MIN_SETTLE) ? MIN_SETTLE : SETTLE_CYC;
    localparam int TW         = $clog2(SETTLE_EFF);
    localparam logic [TW-1:0]  TMR_LOAD   = TW'(SETTLE_EFF - 1);
    // A phase that needs 2^WIDTH steps without its flag can never finish.
    localparam logic [WIDTH:0] STEP_LIMIT = {1'b1, {WIDTH{1'b0}}};

    sweep_state_t     state_q, state_d;
    sweep_phase_t     phase_q, phase_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [NSW_W-1:0] nsw_q, nsw_d;
    logic [WIDTH:0]   step_q, step_d;
    logic [NSW_W-1:0] sweeps_q, sweeps_d;
    logic             error_q, error_d;
    logic             load_en_q, inc_q, dec_q, busy_q, done_q;

    logic [NSW_W-1:0] w_sweeps_inc;
    logic [WIDTH:0]   w_dn_step;
    logic             w_tmr_load;
    logic             w_tmr_zero;

    assign w_sweeps_inc = sweeps_q + NSW_W'(1);

    // Re-arm the settle timer on every entry (or re-entry) into SETTLE.
    assign w_tmr_load = (state_d == ST_SETTLE) && ((state_q != ST_SETTLE) || w_tmr_zero);

    counter_settle_timer #(
        .TW (TW)
    ) u_settle_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (w_tmr_load),
        .load_val_i (TMR_LOAD),
        .zero_o     (w_tmr_zero)
    );

    // Next-state logic: abort overrides everything, then per-state decisions.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        target_d  = target_q;
        nsw_d     = nsw_q;
        step_d    = step_q;
        sweeps_d  = sweeps_q;
        error_d   = error_q;
        w_dn_step = step_q;

        if (bus.abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        target_d = bus.sweep_to;
                        nsw_d    = bus.n_sweeps;
                        error_d  = 1'b0;
                        sweeps_d = '0;
                        step_d   = '0;
                        phase_d  = PH_UP;
                        state_d  = (bus.n_sweeps == '0) ? ST_FIN : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    phase_d = PH_UP;
                    step_d  = '0;
                    state_d = ST_SETTLE;
                end
                ST_UP_STEP, ST_DN_STEP: begin
                    step_d  = step_q + (WIDTH+1)'(1);
                    state_d = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (w_tmr_zero) begin
                        if ((phase_q == PH_UP) && !bus.flag_count_max) begin
                            if (step_q == STEP_LIMIT) begin
                                error_d = 1'b1;
                                state_d = ST_FIN;
                            end else begin
                                state_d = ST_UP_STEP;
                            end
                        end else begin
                            // Top reached in this same cycle starts a fresh down phase.
                            if (phase_q == PH_UP) begin
                                phase_d   = PH_DN;
                                step_d    = '0;
                                w_dn_step = '0;
                            end
                            if (!bus.flag_count_min) begin
                                if (w_dn_step == STEP_LIMIT) begin
                                    error_d = 1'b1;
                                    state_d = ST_FIN;
                                end else begin
                                    state_d = ST_DN_STEP;
                                end
                            end else begin
                                sweeps_d = w_sweeps_inc;
                                step_d   = '0;
                                if (w_sweeps_inc == nsw_q) begin
                                    state_d = ST_FIN;
                                end else if (bus.flag_count_max) begin
                                    // Target 0: already at the top, so the next
                                    // sweep is immediately a down phase.
                                    phase_d = PH_DN;
                                    state_d = ST_SETTLE;
                                end else begin
                                    phase_d = PH_UP;
                                    state_d = ST_UP_STEP;
                                end
                            end
                        end
                    end
                end
                ST_FIN: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            phase_q   <= PH_UP;
            target_q  <= '0;
            nsw_q     <= '0;
            step_q    <= '0;
            sweeps_q  <= '0;
            error_q   <= 1'b0;
            load_en_q <= 1'b0;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            target_q  <= target_d;
            nsw_q     <= nsw_d;
            step_q    <= step_d;
            sweeps_q  <= sweeps_d;
            error_q   <= error_d;
            load_en_q <= (state_d == ST_LOAD);
            inc_q     <= (state_d == ST_UP_STEP);
            dec_q     <= (state_d == ST_DN_STEP);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_FIN);
        end
    end

    assign bus.count_to    = target_q;
    assign bus.load_en     = load_en_q;
    assign bus.count_inc   = inc_q;
    assign bus.count_dec   = dec_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
    assign bus.sweeps_done = sweeps_q;

endmodule : counter_sweep_ctrl
`default_nettype wire

// File: tb/tb_counter_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_sweep_ctrl
//  Description : Scoreboard bench for counter_sweep_ctrl paired with a
//                behavioural up/down Counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_sweep_ctrl;

    localparam int WIDTH      = 4;
    localparam int SETTLE_CYC = 2;
    localparam int NSW_W      = 8;

    localparam int K_LOAD = 0;
    localparam int K_INC  = 1;
    localparam int K_DEC  = 2;
    localparam int K_DONE = 3;

    typedef struct {
        int kind;
        int val;   // load: target; done: error*1000 + sweeps_done
        int gap;   // required cycles since previous pulse, 0 = not checked
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb_q[$];

    counter_sweep_if #(.WIDTH(WIDTH), .NSW_W(NSW_W)) bus ();

    counter_sweep_ctrl #(
        .WIDTH      (WIDTH),
        .SETTLE_CYC (SETTLE_CYC),
        .NSW_W      (NSW_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural Counter: load clears the count and sets the ceiling;
    // flags are registered from the count, so they trail a pulse by 2 cycles.
    logic [WIDTH-1:0] m_cnt = '0;
    logic [WIDTH-1:0] m_tgt = '0;
    logic             m_fmax = 1'b0;
    logic             m_fmin = 1'b0;
    logic             stuck_max = 1'b0;

    always @(posedge clk) begin
        if (bus.load_en === 1'b1) begin
            m_cnt <= '0;
            m_tgt <= bus.count_to;
        end else if (bus.count_inc === 1'b1) begin
            m_cnt <= m_cnt + WIDTH'(1);
        end else if (bus.count_dec === 1'b1) begin
            m_cnt <= m_cnt - WIDTH'(1);
        end
        m_fmax <= (m_cnt == m_tgt);
        m_fmin <= (m_cnt == '0);
    end

    assign bus.flag_count_max = m_fmax & ~stuck_max;
    assign bus.flag_count_min = m_fmin;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push(input int kind, input int val, input int gap);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.gap  = gap;
        sb_q.push_back(e);
    endtask

    // Reference: what the Counter should see for one run, from the sweep rules.
    task automatic predict_run(input int t, input int n, input bit stuck);
        if (n == 0) begin
            push(K_DONE, 0, 0);
            return;
        end
        push(K_LOAD, t, 0);
        if (stuck) begin
            repeat (2**WIDTH) push(K_INC, 0, SETTLE_CYC + 1);
            push(K_DONE, 1000, 0);
            return;
        end
        for (int s = 0; s < n; s++) begin
            repeat (t) push(K_INC, 0, SETTLE_CYC + 1);
            repeat (t) push(K_DEC, 0, SETTLE_CYC + 1);
        end
        push(K_DONE, n, 0);
    endtask

    task automatic observe(input int kind, input int val, input int gap);
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d val %0d, required no event", kind, val);
        end else begin
            e = sb_q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_val", val, e.val);
            if (e.gap > 0) check("pulse_gap", gap, e.gap);
        end
    endtask

    // Monitor: every visible pulse or done is matched against the scoreboard.
    initial begin : monitor
        int k;
        int v;
        int last_cyc;
        last_cyc = 0;
        forever begin
            @(negedge clk);
            k = -1;
            v = 0;
            if ((int'(bus.load_en === 1'b1) + int'(bus.count_inc === 1'b1) + int'(bus.count_dec === 1'b1)) > 1)
                check("pulse_exclusive", 0, 1);
            if (bus.load_en === 1'b1) begin
                k = K_LOAD;
                v = int'(bus.count_to);
            end else if (bus.count_inc === 1'b1) begin
                k = K_INC;
            end else if (bus.count_dec === 1'b1) begin
                k = K_DEC;
            end
            if (k >= 0) begin
                observe(k, v, cyc - last_cyc);
                last_cyc = cyc;
            end
            if (bus.done === 1'b1)
                observe(K_DONE, int'(bus.error) * 1000 + int'(bus.sweeps_done), 0);
        end
    end

    task automatic issue_start(input int t, input int n);
        @(negedge clk);
        bus.sweep_to = WIDTH'(t);
        bus.n_sweeps = NSW_W'(n);
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.sweep_to = WIDTH'($urandom);
        bus.n_sweeps = NSW_W'($urandom);
    endtask

    task automatic wait_done(input int budget, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = budget;
        for (int i = 0; i < budget; i++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
            @(negedge clk);
        end
        check("done_seen", int'(seen), 1);
    endtask

    task automatic wait_pulses(input bit want_dec, input int count, input int budget);
        int c;
        c = 0;
        for (int i = 0; i < budget; i++) begin
            if ((want_dec ? bus.count_dec : bus.count_inc) === 1'b1) c++;
            if (c == count) break;
            @(negedge clk);
        end
        check("pulses_reached", c, count);
    endtask

    task automatic finish_run(input int n, input int err);
        check("busy_at_done", int'(bus.busy), 1);
        check("sweeps_at_done", int'(bus.sweeps_done), (err != 0) ? 0 : n);
        check("error_at_done", int'(bus.error), err);
        @(negedge clk);
        check("busy_after_done", int'(bus.busy), 0);
        check("done_one_cycle", int'(bus.done), 0);
        check("scoreboard_drained", sb_q.size(), 0);
    endtask

    task automatic run_normal(input int t, input int n, input bit inject);
        int lat;
        predict_run(t, n, 1'b0);
        issue_start(t, n);
        check("error_cleared_on_start", int'(bus.error), 0);
        if (inject && n > 0) begin
            // DUT is busy here; this start must change nothing.
            bus.start    = 1'b1;
            bus.sweep_to = WIDTH'($urandom);
            bus.n_sweeps = NSW_W'($urandom_range(1, 255));
            @(negedge clk);
            bus.start    = 1'b0;
        end
        wait_done(4000, lat);
        if (n == 0) check("nsw0_done_latency_ok", int'(lat <= 1), 1);
        finish_run(n, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int lat;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.sweep_to = '0;
        bus.n_sweeps = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_error", int'(bus.error), 0);
        check("rst_sweeps", int'(bus.sweeps_done), 0);
        check("rst_count_to", int'(bus.count_to), 0);
        check("rst_load_en", int'(bus.load_en), 0);
        check("rst_inc", int'(bus.count_inc), 0);
        check("rst_dec", int'(bus.count_dec), 0);
        reset = 1'b0;

        // Directed sweeps
        run_normal(3, 1, 1'b0);
        run_normal(15, 2, 1'b1);
        run_normal(0, 3, 1'b1);
        run_normal(6, 0, 1'b0);

        // Stuck top flag: 2^WIDTH increments then error; next start clears it
        stuck_max = 1'b1;
        predict_run(7, 1, 1'b1);
        issue_start(7, 1);
        wait_done(2000, lat);
        finish_run(1, 1);
        check("error_sticky", int'(bus.error), 1);
        stuck_max = 1'b0;

        // Abort during the 5th increment, with a simultaneous start
        push(K_LOAD, 9, 0);
        repeat (5) push(K_INC, 0, SETTLE_CYC + 1);
        issue_start(9, 1);
        check("error_cleared_by_start", int'(bus.error), 0);
        wait_pulses(1'b0, 5, 200);
        bus.abort    = 1'b1;
        bus.start    = 1'b1;
        bus.sweep_to = WIDTH'(2);
        bus.n_sweeps = NSW_W'(1);
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_inc_drop", int'(bus.count_inc), 0);
        check("abort_no_done", int'(bus.done), 0);
        check("abort_sweeps_hold", int'(bus.sweeps_done), 0);
        check("abort_error_hold", int'(bus.error), 0);
        // Abort with start in IDLE: abort wins
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        check("idle_abort_start_ignored", int'(bus.busy), 0);
        check("abort_scoreboard_drained", sb_q.size(), 0);

        // Reset in the down phase
        push(K_LOAD, 5, 0);
        repeat (5) push(K_INC, 0, SETTLE_CYC + 1);
        push(K_DEC, 0, SETTLE_CYC + 1);
        issue_start(5, 1);
        wait_pulses(1'b1, 1, 200);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_error", int'(bus.error), 0);
        check("mid_rst_sweeps", int'(bus.sweeps_done), 0);
        check("mid_rst_count_to", int'(bus.count_to), 0);
        check("mid_rst_pulses", int'(bus.load_en) + int'(bus.count_inc) + int'(bus.count_dec), 0);
        check("mid_rst_scoreboard_drained", sb_q.size(), 0);

        // Randomised runs
        for (int r = 0; r < 8; r++) begin
            run_normal(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b1);
        end

        repeat (4) @(negedge clk);
        check("final_scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_counter_sweep_ctrl
`default_nettype wire
